afifo_gptr_rx: RTL and testbench

- Receiving end of the async FIFO pointer-crossing path.
- Takes a Gray-coded pointer launched from the remote clock domain and passes it through a multi-flop synchronizer.
- Decodes the synchronized Gray value back to binary and produces the occupancy distance against the local binary pointer.
- Checks that the incoming Gray sequence never changes more than one bit per sample.

---
 rtl/afifo_gptr_rx_if.sv | 27 ++
 rtl/afifo_gptr_rx.sv | 84 ++++++++
 tb/tb_afifo_gptr_rx.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/afifo_gptr_rx_if.sv
// Pointer-crossing bundle between the remote Gray pointer source, the local
// pointer logic and the afifo_gptr_rx receiver.
interface afifo_gptr_rx_if #(
  parameter int ADDR_WIDTH = 4
);
  localparam int PW = ADDR_WIDTH + 1;

  logic [PW-1:0] gray_in;
  logic [PW-1:0] local_bin;
  logic [PW-1:0] gray_sync;
  logic [PW-1:0] bin_sync;
  logic [PW-1:0] level;
  logic          sync_valid;
  logic          ptrs_equal;
  logic          step_err;
  logic          err_sticky;

  modport master (
    output gray_in, local_bin,
    input  gray_sync, bin_sync, level, sync_valid, ptrs_equal, step_err, err_sticky
  );

  modport slave (
    input  gray_in, local_bin,
    output gray_sync, bin_sync, level, sync_valid, ptrs_equal, step_err, err_sticky
  );
endinterface

// File: rtl/afifo_gptr_rx.sv
// Receive side of an async FIFO pointer crossing: Gray synchronizer, Gray to
// binary decode, occupancy distance and single-bit-step integrity check.
module afifo_gptr_rx #(
  parameter int ADDR_WIDTH  = 4,
  parameter int SYNC_STAGES = 2   // legal range 2..4
) (
  input  logic            clk,
  input  logic            rst_n,
  afifo_gptr_rx_if.slave  bus
);
  localparam int            PW       = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] ONE      = PW'(1);
  localparam logic [2:0]    VALID_AT = 3'(SYNC_STAGES);

  logic [PW-1:0] stage [SYNC_STAGES];
  logic [PW-1:0] gray_prev;
  logic [PW-1:0] bin_q;
  logic [PW-1:0] diff;
  logic [PW-1:0] level_w;
  logic [2:0]    valid_cnt;
  logic          valid_q;
  logic          step_q;
  logic          sticky_q;
  logic          illegal;

  function automatic logic [PW-1:0] g2b(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // Plain flop chain, no logic between stages, so metastability only ever
  // has a full cycle to resolve into the next flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the synchronizer array is a handful of flops, not a RAM, so it
      // is reset like any other register; a real memory would not be.
      for (int k = 0; k < SYNC_STAGES; k++) stage[k] <= '0;
    end else begin
      // NOTE: non-blocking assignments make every stage sample the previous
      // stage's old value, which is what turns this loop into a shift chain.
      stage[0] <= bus.gray_in;
      for (int k = 1; k < SYNC_STAGES; k++) stage[k] <= stage[k-1];
    end
  end

  // A Gray value with more than one bit changed means the crossing was
  // corrupted; d & (d-1) is non-zero exactly when popcount(d) >= 2.
  always_comb begin
    // NOTE: defaults first so no path through this block can infer a latch.
    diff    = bus.gray_sync ^ gray_prev;
    illegal = 1'b0;
    if (valid_q && ((diff & (diff - ONE)) != '0)) illegal = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q     <= '0;
      gray_prev <= '0;
      valid_cnt <= '0;
      valid_q   <= 1'b0;
      step_q    <= 1'b0;
      sticky_q  <= 1'b0;
    end else begin
      bin_q     <= g2b(bus.gray_sync);
      gray_prev <= bus.gray_sync;
      if (valid_cnt != VALID_AT) valid_cnt <= valid_cnt + 3'd1;
      // Valid waits until both gray_sync and gray_prev hold real samples.
      valid_q   <= valid_q | (valid_cnt == VALID_AT);
      step_q    <= illegal;
      sticky_q  <= sticky_q | illegal;
    end
  end

  assign level_w        = bin_q - bus.local_bin;
  assign bus.gray_sync  = stage[SYNC_STAGES-1];
  assign bus.bin_sync   = bin_q;
  assign bus.level      = level_w;
  assign bus.ptrs_equal = (level_w == '0);
  assign bus.sync_valid = valid_q;
  assign bus.step_err   = step_q;
  assign bus.err_sticky = sticky_q;
endmodule

// File: tb/tb_afifo_gptr_rx.sv
// Randomized and directed bench for afifo_gptr_rx against a sample-history
// reference model of the pointer crossing.
module tb_afifo_gptr_rx;
  localparam int ADDR_WIDTH  = 4;
  localparam int SYNC_STAGES = 2;
  localparam int PW          = ADDR_WIDTH + 1;
  localparam int NVAL        = 1 << PW;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  afifo_gptr_rx_if #(.ADDR_WIDTH(ADDR_WIDTH)) ifc ();

  afifo_gptr_rx #(.ADDR_WIDTH(ADDR_WIDTH), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want $finish before 2ms");
    $fatal(1, "watchdog");
  end

  // Model state: every gray_in value sampled since the last reset release.
  logic [PW-1:0] hist[$];
  int            n_edges;
  logic          sticky_m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] gray(input int v);
    logic [PW-1:0] b;
    b = PW'(v);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] to_bin(input logic [PW-1:0] g);
    for (int v = 0; v < NVAL; v++) if (gray(v) == g) return PW'(v);
    return '0;
  endfunction

  // Sample k (1-based) reaches gray_sync after edge k+SYNC_STAGES-1.
  function automatic logic [PW-1:0] exp_gs(input int m);
    int idx = m - SYNC_STAGES + 1;
    return (idx >= 1) ? hist[idx-1] : '0;
  endfunction

  function automatic logic [PW-1:0] exp_bs(input int m);
    int idx = m - SYNC_STAGES;
    return (idx >= 1) ? to_bin(hist[idx-1]) : '0;
  endfunction

  function automatic logic exp_valid(input int m);
    return m >= SYNC_STAGES + 1;
  endfunction

  function automatic logic exp_step(input int m);
    if (m < 2 || !exp_valid(m - 1)) return 1'b0;
    return $countones(exp_gs(m - 1) ^ exp_gs(m - 2)) >= 2;
  endfunction

  task automatic compare_all();
    logic [PW-1:0] bs, lvl;
    bs  = exp_bs(n_edges);
    lvl = bs - ifc.local_bin;
    check("gray_sync",  32'(ifc.gray_sync),  32'(exp_gs(n_edges)));
    check("bin_sync",   32'(ifc.bin_sync),   32'(bs));
    check("level",      32'(ifc.level),      32'(lvl));
    check("ptrs_equal", 32'(ifc.ptrs_equal), 32'(lvl == '0));
    check("sync_valid", 32'(ifc.sync_valid), 32'(exp_valid(n_edges)));
    check("step_err",   32'(ifc.step_err),   32'(exp_step(n_edges)));
    check("err_sticky", 32'(ifc.err_sticky), 32'(sticky_m));
  endtask

  // Called and returns at a falling edge.
  task automatic cycle(input logic [PW-1:0] g, input logic [PW-1:0] lb);
    ifc.gray_in   = g;
    ifc.local_bin = lb;
    @(posedge clk);
    hist.push_back(g);
    n_edges++;
    if (exp_step(n_edges)) sticky_m = 1'b1;
    #1;
    compare_all();
    @(negedge clk);
  endtask

  // Asserts reset asynchronously mid-phase; called and returns at a falling edge.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    hist.delete();
    n_edges  = 0;
    sticky_m = 1'b0;
    #1;
    compare_all();
    @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [PW-1:0] g_cur;
  int            r;

  initial begin
    rst_n         = 1'b0;
    ifc.gray_in   = '0;
    ifc.local_bin = '0;
    n_edges       = 0;
    sticky_m      = 1'b0;
    @(negedge clk);

    // Reset state and sync_valid timing.
    do_reset();
    check("rst_ptrs_equal", 32'(ifc.ptrs_equal), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      cycle('0, '0);
      check("valid_edge", 32'(ifc.sync_valid), 32'(i >= 3));
    end

    // Latency, plus the 00000 -> 00011 illegal step.
    cycle(5'b00011, '0);
    cycle(5'b00011, '0);
    check("lat_gray_sync", 32'(ifc.gray_sync), 32'h3);
    cycle(5'b00011, '0);
    check("lat_bin_sync", 32'(ifc.bin_sync), 32'd2);
    check("lat_level",    32'(ifc.level),    32'd2);
    check("lat_step_err", 32'(ifc.step_err), 32'd1);
    cycle(5'b00011, '0);
    check("lat_step_pulse", 32'(ifc.step_err),   32'd0);
    check("lat_sticky",     32'(ifc.err_sticky), 32'd1);

    // Full wrap sweep with random local pointer.
    do_reset();
    for (int i = 0; i < 4; i++) cycle('0, PW'($urandom));
    for (int i = 0; i <= NVAL; i++) cycle(gray(i % NVAL), PW'($urandom));
    for (int i = 0; i < 3; i++) cycle('0, PW'($urandom));
    check("sweep_no_err", 32'(ifc.err_sticky), 32'd0);

    // Modulo level and full indication.
    do_reset();
    for (int i = 0; i < 5; i++) cycle(gray(1), PW'(30));
    check("mod_level", 32'(ifc.level), 32'd3);
    for (int i = 0; i < 4; i++) cycle(gray(16), '0);
    check("full_level", 32'(ifc.level),      32'd16);
    check("full_equal", 32'(ifc.ptrs_equal), 32'd0);

    // Reset mid-sweep, resuming with a nonzero pointer.
    do_reset();
    for (int i = 0; i < 4; i++) cycle('0, '0);
    for (int i = 0; i < 10; i++) cycle(gray(i), '0);
    do_reset();
    for (int i = 10; i < NVAL; i++) cycle(gray(i), '0);
    check("midrst_no_err", 32'(ifc.err_sticky), 32'd0);

    // Random walk: mostly legal steps, occasional jumps and resets.
    do_reset();
    g_cur = '0;
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        do_reset();
      end else begin
        if (r < 8)       g_cur = PW'($urandom);
        else if (r < 30) g_cur = g_cur;
        else             g_cur = g_cur ^ (PW'(1) << $urandom_range(0, PW - 1));
        cycle(g_cur, PW'($urandom));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
